// File: rtl/tick_rate_ctrl_pkg.sv
// Shared types and defaults for the tick rate controller.
package tick_rate_pkg;
    localparam int CNT_W       = 27;
    localparam int DEFAULT_DIV = 833333;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        ONESHOT = 2'd2
    } state_t;
endpackage

// File: rtl/tick_rate_ctrl_if.sv
// Divisor reload handshake between a configuring master and the rate controller.
interface tick_rate_ctrl_if
    import tick_rate_pkg::*;
#(
    parameter int CNT_W = tick_rate_pkg::CNT_W
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_div, output cfg_ready);
endinterface

// File: rtl/tick_rate_ctrl_counter.sv
// Up-counter with equality terminal-count compare; clr wins over en.
module tick_counter #(
    parameter int CNT_W = 27
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tc
);
    logic [CNT_W-1:0] count;

    assign tc = (count == div);

    always_ff @(posedge clk_in) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tick_rate_ctrl.sv
// Programmable tick/clk_out rate controller with run and single-shot modes.
// Optional TICK_RATE_CNT_EN adds a 16-bit wrapping tick counter output.
module tick_rate_ctrl
    import tick_rate_pkg::*;
#(
    parameter int CNT_W       = tick_rate_pkg::CNT_W,
    parameter int DEFAULT_DIV = tick_rate_pkg::DEFAULT_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic             oneshot,
    tick_rate_ctrl_if.slave  cfg,
    output logic             tick,
    output logic             clk_out,
    output logic             busy
`ifdef TICK_RATE_CNT_EN
    ,
    output logic [15:0]      tick_cnt
`endif
);
    // state   | meaning
    // IDLE    | stopped, counter and clk_out held at 0, divisor loads directly
    // RUN     | continuous ticking while run is high
    // ONESHOT | one tick period, then back to IDLE
    state_t           state, state_d;
    logic [CNT_W-1:0] div_q, pend_div;
    logic             pend_v;
    logic             tc, tick_d, xfer, to_idle, clr;

    assign cfg.cfg_ready = ~pend_v;
    assign xfer          = cfg.cfg_valid & ~pend_v;
    assign busy          = (state != IDLE);
    assign to_idle       = busy & (state_d == IDLE);
    assign clr           = (state == IDLE) | to_idle;

    tick_counter #(.CNT_W(CNT_W)) u_counter (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (busy),
        .clr    (clr),
        .div    (div_q),
        .tc     (tc)
    );

    always_comb begin
        state_d = state;
        tick_d  = 1'b0;
        case (state)
            IDLE: begin
                if (run)          state_d = RUN;
                else if (oneshot) state_d = ONESHOT;
            end
            RUN: begin
                if (!run)    state_d = IDLE;
                else if (tc) tick_d  = 1'b1;
            end
            ONESHOT: begin
                if (tc)       tick_d  = 1'b1;
                if (run)      state_d = RUN;
                else if (tc)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new divisor takes effect only at a terminal count or on IDLE entry,
    // so the running period never gets cut short.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
            div_q    <= CNT_W'(DEFAULT_DIV);
            pend_div <= '0;
            pend_v   <= 1'b0;
        end else begin
            state <= state_d;
            tick  <= tick_d;
            if (state_d == IDLE) clk_out <= 1'b0;
            else if (tick_d)     clk_out <= ~clk_out;

            if (state == IDLE) begin
                if (xfer) div_q <= cfg.cfg_div;
            end else if (to_idle) begin
                if (xfer)        div_q <= cfg.cfg_div;
                else if (pend_v) div_q <= pend_div;
                pend_v <= 1'b0;
            end else if (tick_d) begin
                if (pend_v) div_q <= pend_div;
                pend_v <= xfer;
                if (xfer) pend_div <= cfg.cfg_div;
            end else if (xfer) begin
                pend_v   <= 1'b1;
                pend_div <= cfg.cfg_div;
            end
        end
    end

`ifdef TICK_RATE_CNT_EN
    always_ff @(posedge clk_in) begin
        if (reset)       tick_cnt <= '0;
        else if (tick_d) tick_cnt <= tick_cnt + 16'd1;
    end
`endif
endmodule
